// File: rtl/tile_cmd_scheduler_pkg.sv
// Shared types and constants for the tile command scheduler.
package tile_cmd_scheduler_pkg;

    localparam int RESULT_FIFO_DEPTH_GP = 64;
    localparam int TILE_ADDR_W_GP       = 11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_WAIT_CRED = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [TILE_ADDR_W_GP-1:0] left_addr;
        logic [TILE_ADDR_W_GP-1:0] right_addr;
        logic [7:0]                dim_b;
        logic [7:0]                dim_c;
        logic [7:0]                dim_v;
        logic [2:0]                flags;
    } tile_cmd_t;

    // Number of FP16 results a tile produces (B x C), zero-extended to 16 bits.
    function automatic logic [15:0] tile_bc(input logic [7:0] b, input logic [7:0] c);
        return {8'd0, b} * {8'd0, c};
    endfunction

endpackage

// File: rtl/tile_cmd_scheduler_if.sv
// Tile command valid/ready bus from the command decoder to the scheduler.
interface tile_cmd_scheduler_if #(
    parameter int ADDR_W = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_left_addr;
    logic [ADDR_W-1:0] cmd_right_addr;
    logic [7:0]        cmd_dim_b;
    logic [7:0]        cmd_dim_c;
    logic [7:0]        cmd_dim_v;
    logic [2:0]        cmd_flags;

    modport master (
        output cmd_valid, cmd_left_addr, cmd_right_addr,
               cmd_dim_b, cmd_dim_c, cmd_dim_v, cmd_flags,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_left_addr, cmd_right_addr,
               cmd_dim_b, cmd_dim_c, cmd_dim_v, cmd_flags,
        output cmd_ready
    );
endinterface

// File: rtl/tile_cmd_scheduler_result_credit_counter.sv
// Free-space credit counter for the result FIFO. Issue consumes bc credits,
// each pop returns one; a pop at full credit is flagged and dropped.
module result_credit_counter #(
    parameter int RESULT_DEPTH = 64,
    parameter int CREDIT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_issue,
    input  logic [CREDIT_W-1:0] i_bc,
    input  logic                i_pop,
    output logic [CREDIT_W-1:0] o_credits,
    output logic                o_credit_err
);
    localparam logic [CREDIT_W-1:0] L_FULL = CREDIT_W'(RESULT_DEPTH);

    logic [CREDIT_W-1:0] r_credits;
    logic                r_credit_err;
    logic [CREDIT_W-1:0] w_next;
    logic                w_err_set;
    logic [CREDIT_W-1:0] w_pop_ext;

    assign w_pop_ext = {{(CREDIT_W-1){1'b0}}, i_pop};

    // Next credit value: issue and pop both apply; an unmatched pop at full is dropped.
    always_comb begin
        w_next    = r_credits;
        w_err_set = 1'b0;
        if (i_issue) begin
            w_next = r_credits - i_bc + w_pop_ext;
        end else if (i_pop) begin
            if (r_credits == L_FULL) begin
                w_err_set = 1'b1;
            end else begin
                w_next = r_credits + w_pop_ext;
            end
        end
    end

    // Credit register and sticky overflow flag, both restored by reset only.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_credits    <= L_FULL;
            r_credit_err <= 1'b0;
        end else begin
            r_credits <= w_next;
            if (w_err_set) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign o_credits    = r_credits;
    assign o_credit_err = r_credit_err;

endmodule

// File: rtl/tile_cmd_scheduler.sv
// Tile command scheduler: accepts a tile command, validates its dimensions,
// waits for result-FIFO credit, pulses o_tile_en once and then waits for the
// engine to report the tile done before accepting another command.
module tile_cmd_scheduler
    import tile_cmd_scheduler_pkg::*;
#(
    parameter int ADDR_W       = TILE_ADDR_W_GP,
    parameter int RESULT_DEPTH = RESULT_FIFO_DEPTH_GP,
    parameter int CREDIT_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    tile_cmd_scheduler_if.slave    cmd_if,
    output logic                   o_tile_en,
    output logic [ADDR_W-1:0]      o_left_addr,
    output logic [ADDR_W-1:0]      o_right_addr,
    output logic [7:0]             o_dim_b,
    output logic [7:0]             o_dim_c,
    output logic [7:0]             o_dim_v,
    output logic [2:0]             o_flags,
    input  logic                   i_tile_done,
    input  logic                   i_result_pop,
    output logic                   o_cmd_err,
    output logic                   o_credit_err,
    output logic                   o_busy,
    output logic [CREDIT_W-1:0]    o_credits,
    output logic [15:0]            o_tiles_done,
    output logic [2:0]             o_state
);
    localparam logic [CREDIT_W-1:0] L_DEPTH = CREDIT_W'(RESULT_DEPTH);

    sched_state_t        r_state;
    sched_state_t        w_next_state;
    logic [ADDR_W-1:0]   r_left_addr;
    logic [ADDR_W-1:0]   r_right_addr;
    logic [7:0]          r_dim_b;
    logic [7:0]          r_dim_c;
    logic [7:0]          r_dim_v;
    logic [2:0]          r_flags;
    logic [CREDIT_W-1:0] r_bc;
    logic [15:0]         r_tiles_done;
    logic [CREDIT_W-1:0] w_credits;
    logic                w_accept;
    logic                w_dim_bad;
    logic                w_issue;

    assign w_accept  = (r_state == S_IDLE) && cmd_if.cmd_valid;
    assign w_issue   = (r_state == S_ISSUE);
    assign w_dim_bad = (r_dim_b == 8'd0) || (r_dim_c == 8'd0) || (r_dim_v == 8'd0) ||
                       (r_bc > L_DEPTH);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ISSUE is entered only once credits cover the tile.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next_state = S_CHECK;
            S_CHECK:     w_next_state = w_dim_bad ? S_IDLE : S_WAIT_CRED;
            S_WAIT_CRED: if (w_credits >= r_bc) w_next_state = S_ISSUE;
            S_ISSUE:     w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (i_tile_done) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Latch command fields and the B x C product on accept; held until the next accept.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_left_addr  <= '0;
            r_right_addr <= '0;
            r_dim_b      <= '0;
            r_dim_c      <= '0;
            r_dim_v      <= '0;
            r_flags      <= '0;
            r_bc         <= '0;
        end else if (w_accept) begin
            r_left_addr  <= cmd_if.cmd_left_addr;
            r_right_addr <= cmd_if.cmd_right_addr;
            r_dim_b      <= cmd_if.cmd_dim_b;
            r_dim_c      <= cmd_if.cmd_dim_c;
            r_dim_v      <= cmd_if.cmd_dim_v;
            r_flags      <= cmd_if.cmd_flags;
            r_bc         <= CREDIT_W'(tile_bc(cmd_if.cmd_dim_b, cmd_if.cmd_dim_c));
        end
    end

    // Completed-tile counter; done pulses outside WAIT_DONE are ignored.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tiles_done <= '0;
        end else if ((r_state == S_WAIT_DONE) && i_tile_done) begin
            r_tiles_done <= r_tiles_done + 16'd1;
        end
    end

    result_credit_counter #(
        .RESULT_DEPTH (RESULT_DEPTH),
        .CREDIT_W     (CREDIT_W)
    ) u_credit (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_issue      (w_issue),
        .i_bc         (r_bc),
        .i_pop        (i_result_pop),
        .o_credits    (w_credits),
        .o_credit_err (o_credit_err)
    );

    assign cmd_if.cmd_ready = (r_state == S_IDLE);
    assign o_tile_en        = w_issue;
    assign o_cmd_err        = (r_state == S_CHECK) && w_dim_bad;
    assign o_busy           = (r_state != S_IDLE);
    assign o_state          = r_state;
    assign o_credits        = w_credits;
    assign o_tiles_done     = r_tiles_done;
    assign o_left_addr      = r_left_addr;
    assign o_right_addr     = r_right_addr;
    assign o_dim_b          = r_dim_b;
    assign o_dim_c          = r_dim_c;
    assign o_dim_v          = r_dim_v;
    assign o_flags          = r_flags;

endmodule

// File: tb/tb_tile_cmd_scheduler.sv
// Self-checking bench for tile_cmd_scheduler: directed steps followed by a
// randomized command stream, checked against a transaction-level model.
module tb_tile_cmd_scheduler;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 64;

    logic        i_clk;
    logic        i_reset_n;
    logic        o_tile_en;
    logic [10:0] o_left_addr;
    logic [10:0] o_right_addr;
    logic [7:0]  o_dim_b;
    logic [7:0]  o_dim_c;
    logic [7:0]  o_dim_v;
    logic [2:0]  o_flags;
    logic        i_tile_done;
    logic        i_result_pop;
    logic        o_cmd_err;
    logic        o_credit_err;
    logic        o_busy;
    logic [15:0] o_credits;
    logic [15:0] o_tiles_done;
    logic [2:0]  o_state;

    tile_cmd_scheduler_if #(.ADDR_W(ADDR_W)) cmd_if ();

    tile_cmd_scheduler #(
        .ADDR_W       (ADDR_W),
        .RESULT_DEPTH (DEPTH),
        .CREDIT_W     (16)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .cmd_if       (cmd_if.slave),
        .o_tile_en    (o_tile_en),
        .o_left_addr  (o_left_addr),
        .o_right_addr (o_right_addr),
        .o_dim_b      (o_dim_b),
        .o_dim_c      (o_dim_c),
        .o_dim_v      (o_dim_v),
        .o_flags      (o_flags),
        .i_tile_done  (i_tile_done),
        .i_result_pop (i_result_pop),
        .o_cmd_err    (o_cmd_err),
        .o_credit_err (o_credit_err),
        .o_busy       (o_busy),
        .o_credits    (o_credits),
        .o_tiles_done (o_tiles_done),
        .o_state      (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Reference model state (values expected after the most recent edge)
    int m_cred;
    bit m_err;
    int m_done;
    bit m_issue;
    int m_bc;
    logic [48:0] m_fields;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rpop();
        return ($urandom_range(0, 2) == 0);
    endfunction

    function automatic logic [48:0] dut_fields();
        return {o_left_addr, o_right_addr, o_dim_b, o_dim_c, o_dim_v, o_flags};
    endfunction

    // Advance one clock; the model applies the credit rule to the inputs driven
    // during the cycle that is ending.
    task automatic tick();
        if (m_issue) begin
            m_cred = m_cred - m_bc + (i_result_pop ? 1 : 0);
        end else if (i_result_pop) begin
            if (m_cred == DEPTH) m_err = 1'b1;
            else m_cred = m_cred + 1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        m_cred   = DEPTH;
        m_err    = 1'b0;
        m_done   = 0;
        m_issue  = 1'b0;
        m_bc     = 0;
        m_fields = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, cmd_if.cmd_ready, 1'b1);
        chk({tag, "_credits"}, o_credits, m_cred);
        chk({tag, "_credit_err"}, o_credit_err, m_err);
        chk({tag, "_tiles"}, o_tiles_done, m_done);
    endtask

    // pop_mode: 0 none, 1 random, 2 pop only while credits are short.
    // pop_iss: 0 none, 1 pop on the issue cycle, 2 random.
    // done_pops: pops in WAIT_DONE (-1 random). hold: leave the FSM in WAIT_DONE.
    task automatic do_cmd(input int b, input int c, input int v, input int pop_mode,
                          input int pop_iss, input int exp_lat, input int done_pops,
                          input bit hold);
        int lat;
        int bc;
        int waited;
        int n;
        bit bad;
        bit go;
        logic [10:0] la;
        logic [10:0] ra;
        logic [2:0]  fl;
        bc  = b * c;
        bad = (b == 0) || (c == 0) || (v == 0) || (bc > DEPTH);
        la  = 11'($urandom);
        ra  = 11'($urandom);
        fl  = 3'($urandom);
        m_fields = {la, ra, 8'(b), 8'(c), 8'(v), fl};

        cmd_if.cmd_valid      = 1'b1;
        cmd_if.cmd_left_addr  = la;
        cmd_if.cmd_right_addr = ra;
        cmd_if.cmd_dim_b      = 8'(b);
        cmd_if.cmd_dim_c      = 8'(c);
        cmd_if.cmd_dim_v      = 8'(v);
        cmd_if.cmd_flags      = fl;
        i_tile_done  = 1'b0;
        i_result_pop = (pop_mode == 1) ? rpop() : 1'b0;
        lat = 0;
        tick();
        lat++;
        cmd_if.cmd_valid = 1'b0;

        chk("check_ready_low", cmd_if.cmd_ready, 1'b0);
        chk("check_busy", o_busy, 1'b1);
        chk("check_state", o_state, 3'd1);
        chk("check_fields", dut_fields(), m_fields);
        chk("cmd_err", o_cmd_err, bad);
        chk("check_no_tile_en", o_tile_en, 1'b0);

        i_result_pop = (pop_mode == 1) ? rpop() : 1'b0;
        tick();
        lat++;
        chk("cmd_err_cleared", o_cmd_err, 1'b0);
        if (bad) begin
            chk("reject_state_idle", o_state, 3'd0);
            chk("reject_no_tile_en", o_tile_en, 1'b0);
            chk_idle("reject");
            i_result_pop = 1'b0;
            return;
        end

        m_bc   = bc;
        waited = 0;
        while (1) begin
            chk("wait_no_tile_en", o_tile_en, 1'b0);
            chk("wait_credits", o_credits, m_cred);
            go = (m_cred >= bc);
            case (pop_mode)
                1:       i_result_pop = rpop();
                2:       i_result_pop = (m_cred < bc);
                default: i_result_pop = 1'b0;
            endcase
            i_tile_done = (pop_mode == 1) ? rpop() : 1'b0;
            tick();
            lat++;
            if (go) break;
            waited++;
            if (waited > 2000) begin
                fails++;
                tests++;
                $error("FAIL wait_cred_timeout observed=%0d expected<=2000", waited);
                i_result_pop = 1'b0;
                i_tile_done  = 1'b0;
                return;
            end
        end
        i_tile_done = 1'b0;

        chk("tile_en", o_tile_en, 1'b1);
        chk("issue_state", o_state, 3'd3);
        chk("issue_fields", dut_fields(), m_fields);
        if (exp_lat >= 0) chk("issue_latency", lat, exp_lat);

        m_issue = 1'b1;
        i_result_pop = (pop_iss == 1) ? 1'b1 : (pop_iss == 2) ? rpop() : 1'b0;
        tick();
        m_issue = 1'b0;
        chk("tile_en_once", o_tile_en, 1'b0);
        chk("post_issue_state", o_state, 3'd4);
        chk("post_issue_credits", o_credits, m_cred);
        chk("wait_done_fields", dut_fields(), m_fields);

        n = (done_pops < 0) ? $urandom_range(0, 20) : done_pops;
        for (int i = 0; i < n; i++) begin
            i_result_pop = (done_pops < 0) ? rpop() : 1'b1;
            tick();
            chk("wait_done_ready_low", cmd_if.cmd_ready, 1'b0);
        end
        i_result_pop = 1'b0;
        if (hold) return;

        i_tile_done = 1'b1;
        tick();
        i_tile_done = 1'b0;
        m_done++;
        chk("done_state_idle", o_state, 3'd0);
        chk_idle("done");
    endtask

    initial begin
        i_reset_n        = 1'b0;
        i_tile_done      = 1'b0;
        i_result_pop     = 1'b0;
        cmd_if.cmd_valid      = 1'b0;
        cmd_if.cmd_left_addr  = '0;
        cmd_if.cmd_right_addr = '0;
        cmd_if.cmd_dim_b      = '0;
        cmd_if.cmd_dim_c      = '0;
        cmd_if.cmd_dim_v      = '0;
        cmd_if.cmd_flags      = '0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_state", o_state, 3'd0);
        chk("reset_ready", cmd_if.cmd_ready, 1'b1);
        chk("reset_credits", o_credits, 16'd64);
        chk("reset_outputs", {o_tile_en, o_cmd_err, o_credit_err, o_busy, o_tiles_done, dut_fields()}, '0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();

        // Basic 4x4 tile with full credits
        do_cmd(4, 4, 2, 0, 0, 3, 0, 1'b1);
        chk("basic_credits_48", o_credits, 16'd48);
        i_tile_done = 1'b1;
        tick();
        i_tile_done = 1'b0;
        m_done++;
        chk("basic_tiles_1", o_tiles_done, 16'd1);
        chk_idle("basic");
        repeat (16) begin i_result_pop = 1'b1; tick(); end
        i_result_pop = 1'b0;
        chk("refill_64", o_credits, 16'd64);

        // Rejections: zero dimension and oversize product
        do_cmd(0, 4, 1, 0, 0, -1, 0, 1'b0);
        chk("zero_dim_credits", o_credits, 16'd64);
        do_cmd(8, 9, 1, 0, 0, -1, 0, 1'b0);
        do_cmd(4, 4, 0, 0, 0, -1, 0, 1'b0);

        // Full-depth tile drains all credits
        do_cmd(8, 8, 1, 0, 0, 3, 0, 1'b0);
        chk("full_depth_credits_0", o_credits, 16'd0);

        // Stalls in WAIT_CRED until four pops arrive, then refill to 16
        do_cmd(2, 2, 1, 2, 0, 7, 16, 1'b0);
        chk("refill_16", o_credits, 16'd16);

        // Pop coincident with issue: 16 - 16 + 1
        do_cmd(4, 4, 3, 0, 1, 3, 0, 1'b1);
        chk("issue_pop_credits_1", o_credits, 16'd1);
        repeat (63) begin i_result_pop = 1'b1; tick(); end
        i_result_pop = 1'b0;
        i_tile_done = 1'b1;
        tick();
        i_tile_done = 1'b0;
        m_done++;
        chk_idle("issue_pop");

        // Spurious done in IDLE is not counted
        i_tile_done = 1'b1;
        tick();
        i_tile_done = 1'b0;
        chk("spurious_done", o_tiles_done, m_done);

        // Pop at full credit sets the sticky error
        i_result_pop = 1'b1;
        tick();
        i_result_pop = 1'b0;
        chk("overflow_err", o_credit_err, 1'b1);
        chk("overflow_credits", o_credits, 16'd64);
        tick();
        chk("overflow_sticky", o_credit_err, 1'b1);

        // Asynchronous reset while waiting for done
        do_cmd(3, 3, 1, 0, 0, 3, 2, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("midreset_state", o_state, 3'd0);
        chk("midreset_credits", o_credits, 16'd64);
        chk("midreset_err", o_credit_err, 1'b0);
        chk("midreset_ready", cmd_if.cmd_ready, 1'b1);
        chk("midreset_outputs", {o_tile_en, o_busy, o_tiles_done, dut_fields()}, '0);
        model_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();

        // Randomized command stream
        for (int k = 0; k < 60; k++) begin
            int nidle;
            do_cmd($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3),
                   1, 2, -1, -1, 1'b0);
            nidle = $urandom_range(0, 3);
            for (int j = 0; j < nidle; j++) begin
                i_result_pop = rpop();
                i_tile_done  = rpop();
                tick();
                chk("rand_idle_credits", o_credits, m_cred);
                chk("rand_idle_tiles", o_tiles_done, m_done);
            end
            i_result_pop = 1'b0;
            i_tile_done  = 1'b0;
        end
        chk_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
